dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/rv32i_pkg.sv | 23 ++
 rtl/dmem_align.sv | 69 ++++++
 rtl/dmem_responder.sv | 142 ++++++++++++++
 tb/tb_dmem_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the data-memory responder.
//   XLEN          : architectural data width
//   mem_size_e    : funct3 encoding of load/store size and signedness
//   dmem_state_e  : responder FSM states
package rv32i_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_e;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_align.sv
// Combinational lane steering for byte-addressed accesses to a word memory.
//   size       : funct3 access size/signedness
//   we         : 1 = store, 0 = load
//   addr_lo    : byte offset within the word
//   wdata      : right-aligned store data
//   rword      : full word read from storage
//   be         : byte-lane write enables (zero when the access is not legal)
//   wdata_lane : store data replicated across the lanes
//   rdata_ext  : selected load lane, sign/zero extended
//   misalign   : offset not a multiple of the access size
//   illegal    : reserved size, or unsigned size used for a store
module dmem_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  size,
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misalign,
  output logic        illegal
);

  logic [31:0] shifted;

  always_comb begin
    be         = '0;
    wdata_lane = '0;
    rdata_ext  = '0;
    misalign   = 1'b0;
    illegal    = 1'b0;
    // Bring the addressed lane down to bit 0 for the extension step.
    shifted    = rword >> {addr_lo, 3'b000};
    case (size)
      MEM_B: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{shifted[7]}}, shifted[7:0]};
      end
      MEM_BU: begin
        illegal   = we;
        rdata_ext = {24'b0, shifted[7:0]};
      end
      MEM_H: begin
        misalign   = addr_lo[0];
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{shifted[15]}}, shifted[15:0]};
      end
      MEM_HU: begin
        misalign  = addr_lo[0];
        illegal   = we;
        rdata_ext = {16'b0, shifted[15:0]};
      end
      MEM_W: begin
        misalign   = (addr_lo != 2'b00);
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rword;
      end
      default: illegal = 1'b1;
    endcase
    if (misalign || illegal) be = '0;
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed access latency.
//   clk, rst_n          : clock, async active-low reset
//   req_valid/req_ready : request handshake (ready only when idle)
//   req_we, req_addr, req_wdata, req_size : access description (captured on accept)
//   resp_valid/resp_ready : response handshake, held until acknowledged
//   resp_rdata, resp_err  : extended load data (0 for stores/errors), error flag
//
// state      | meaning
// -----------+----------------------------------------------------------
// DMEM_IDLE  | ready for a request
// DMEM_WAIT  | request captured, latency counter running down to 0
// DMEM_RESP  | response presented, waiting for resp_ready
module dmem_responder
  import rv32i_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_state_e state, state_nxt;

  logic [3:0]      cnt;
  logic            we_q;
  logic [31:0]     addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [2:0]      size_q;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic            accept;
  logic            go_resp;
  logic            oor;
  logic            err_any;
  logic            commit;
  logic [AW-1:0]   widx;
  logic [XLEN-1:0] rword;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata_lane;
  logic [XLEN-1:0] rdata_ext;
  logic            misalign;
  logic            illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DMEM_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    go_resp   = 1'b0;
    case (state)
      DMEM_IDLE: begin
        accept = req_valid;
        if (req_valid) state_nxt = DMEM_WAIT;
      end
      DMEM_WAIT: begin
        go_resp = (cnt == 4'd0);
        if (cnt == 4'd0) state_nxt = DMEM_RESP;
      end
      DMEM_RESP: begin
        if (resp_ready) state_nxt = DMEM_IDLE;
      end
      default: state_nxt = DMEM_IDLE;
    endcase
  end

  // Ready is masked while reset is held so nothing is offered before release.
  assign req_ready  = (state == DMEM_IDLE) && rst_n;
  assign resp_valid = (state == DMEM_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= 4'(LATENCY - 1);
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= req_size;
      end else if (state == DMEM_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (go_resp) begin
        resp_err   <= err_any;
        resp_rdata <= (err_any || we_q) ? '0 : rdata_ext;
      end
    end
  end

  assign widx    = addr_q[AW+1:2];
  assign oor     = (addr_q[31:2] >= 30'(DEPTH_WORDS));
  assign err_any = misalign || illegal || oor;
  assign rword   = mem[widx];
  // Stores land only on the WAIT->RESP edge, so a reset during WAIT drops them.
  assign commit  = go_resp && we_q && !err_any;

  dmem_align u_align (
    .size       (size_q),
    .we         (we_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .rword      (rword),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .misalign   (misalign),
    .illegal    (illegal)
  );

  // Storage has no reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_size;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] mm [DEPTH*4];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [16];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_size   (req_size),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Byte-array reference: legality, alignment and range from the access rules.
  function automatic void model_access(input logic we, input logic [31:0] addr,
                                       input logic [2:0] size, input logic [31:0] wdata,
                                       output logic err, output logic [31:0] rdata);
    int nb;
    bit legal;
    logic [31:0] v;
    legal = we ? (size <= 3'd2) : (size == 3'd0 || size == 3'd1 || size == 3'd2 ||
                                   size == 3'd4 || size == 3'd5);
    nb    = 1 << size[1:0];
    err   = !legal || ((addr % 32'(nb)) != 0) || ((addr >> 2) >= 32'(DEPTH));
    rdata = '0;
    if (err) return;
    if (we) begin
      for (int k = 0; k < nb; k++) mm[int'(addr) + k] = wdata[8*k +: 8];
    end else begin
      v = '0;
      for (int k = 0; k < nb; k++) v = v | (32'(mm[int'(addr) + k]) << (8*k));
      if (size[2] == 1'b0 && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
      rdata = v;
    end
  endfunction

  // One full request/response exchange, called at posedge+1 with the FSM idle.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input int hold,
                        input logic exp_err, input logic [31:0] exp_rdata, input string name);
    int cyc;
    chk({name, " ready_idle"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_size  = size;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = $urandom_range(0, 1);
    req_addr  = $urandom();
    req_wdata = $urandom();
    req_size  = 3'($urandom_range(0, 7));
    cyc = 0;
    while (!resp_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, " latency"}, cyc, LAT);
    if (!resp_valid) return;
    chk({name, " err"}, {31'b0, resp_err}, {31'b0, exp_err});
    chk({name, " rdata"}, resp_rdata, exp_rdata);
    chk({name, " ready_busy"}, {31'b0, req_ready}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({name, " hold_valid"}, {31'b0, resp_valid}, 32'd1);
      chk({name, " hold_rdata"}, resp_rdata, exp_rdata);
      chk({name, " hold_err"}, {31'b0, resp_err}, {31'b0, exp_err});
      chk({name, " hold_ready"}, {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({name, " ack_valid"}, {31'b0, resp_valid}, 32'd0);
    chk({name, " ack_ready"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    logic        e;
    logic [31:0] r;
    int          cyc;

    vecs[0]  = '{1'b1, 32'h10,  3'b010, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h10,  3'b010, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 32'h13,  3'b000, 32'h0,        1'b0, 32'hFFFFFFDE};
    vecs[3]  = '{1'b0, 32'h13,  3'b100, 32'h0,        1'b0, 32'h000000DE};
    vecs[4]  = '{1'b0, 32'h12,  3'b001, 32'h0,        1'b0, 32'hFFFFDEAD};
    vecs[5]  = '{1'b0, 32'h10,  3'b101, 32'h0,        1'b0, 32'h0000BEEF};
    vecs[6]  = '{1'b1, 32'h11,  3'b000, 32'h12,       1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h10,  3'b010, 32'h0,        1'b0, 32'hDEAD12EF};
    vecs[8]  = '{1'b0, 32'h12,  3'b010, 32'h0,        1'b1, 32'h0};
    vecs[9]  = '{1'b1, 32'h13,  3'b001, 32'hAAAA,     1'b1, 32'h0};
    vecs[10] = '{1'b0, 32'(DEPTH*4), 3'b010, 32'h0,   1'b1, 32'h0};
    vecs[11] = '{1'b0, 32'h10,  3'b010, 32'h0,        1'b0, 32'hDEAD12EF};
    vecs[12] = '{1'b0, 32'h10,  3'b011, 32'h0,        1'b1, 32'h0};
    vecs[13] = '{1'b1, 32'h10,  3'b100, 32'h55,       1'b1, 32'h0};
    vecs[14] = '{1'b0, 32'h10,  3'b010, 32'h0,        1'b0, 32'hDEAD12EF};
    vecs[15] = '{1'b1, 32'h10,  3'b010, 32'hDEADBEEF, 1'b0, 32'h0};

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_size   = '0;
    resp_ready = 1'b0;
    #12;
    chk("rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'b0, resp_err}, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < 16; i++) begin
      model_access(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].wdata, e, r);
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].wdata, 0,
             vecs[i].err, vecs[i].rdata, $sformatf("vec%0d", i));
    end

    // Response held off for five cycles.
    do_txn(1'b0, 32'h10, 3'b010, 32'h0, 5, 1'b0, 32'hDEADBEEF, "hold5");

    // Reset during WAIT of a store: nothing committed, outputs cleared at once.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_size = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rstwait_valid", {31'b0, resp_valid}, 32'd0);
    chk("rstwait_rdata", resp_rdata, 32'd0);
    chk("rstwait_err", {31'b0, resp_err}, 32'd0);
    #2 rst_n = 1'b1;
    #1;
    chk("rstwait_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstwait_idle_valid", {31'b0, resp_valid}, 32'd0);
    do_txn(1'b0, 32'h10, 3'b010, 32'h0, 0, 1'b0, 32'hDEADBEEF, "after_rstwait");

    // Reset while a response is presented: it is dropped without acknowledge.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 0;
    while (!resp_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rstresp_reached", {31'b0, resp_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstresp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rstresp_rdata", resp_rdata, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstresp_ready", {31'b0, req_ready}, 32'd1);

    // Random phase: fill every word, then mixed accesses against the byte model.
    for (int w = 0; w < DEPTH; w++) begin
      logic [31:0] d;
      d = $urandom();
      model_access(1'b1, 32'(w*4), 3'b010, d, e, r);
      do_txn(1'b1, 32'(w*4), 3'b010, d, 0, e, r, "fill");
    end
    for (int n = 0; n < 300; n++) begin
      logic        we;
      logic [31:0] a;
      logic [2:0]  sz;
      logic [31:0] d;
      we = $urandom_range(0, 1);
      sz = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 15) == 0) ? $urandom() : 32'($urandom_range(0, DEPTH*4 + 15));
      d  = $urandom();
      model_access(we, a, sz, d, e, r);
      do_txn(we, a, sz, d, $urandom_range(0, 2), e, r, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
